mips_multicycle_control: RTL

Multi-cycle control unit for the MIPS datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles, so one ALU and one unified memory are shared. Covers R-type, ADDI, LW, SW, BEQ, BNE and J, with a configurable memory latency and an illegal-opcode trap. Sits beside the datapath, driving its register enables and mux selects from the IR opcode.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/mips_multicycle_control_if.sv | 38 +++
 rtl/mips_multicycle_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle control unit: opcodes, FSM states
// and the mux/ALU select codes driven onto the datapath.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;

    // IR[31:26] opcodes handled by the control unit
    localparam logic [OPCODE_W-1:0] R_TYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] ADDI   = 6'h08;
    localparam logic [OPCODE_W-1:0] LW     = 6'h23;
    localparam logic [OPCODE_W-1:0] SW     = 6'h2B;
    localparam logic [OPCODE_W-1:0] BEQ    = 6'h04;
    localparam logic [OPCODE_W-1:0] BNE    = 6'h05;
    localparam logic [OPCODE_W-1:0] J      = 6'h02;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // alu_op
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // pc_src
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // States that hold a memory access for MEM_LAT cycles
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle control unit (master) and the
// datapath (slave): opcode in, enables and mux selects out.
interface mips_multicycle_control_if;
    import mips_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic                instr_done;
    logic                illegal;

    modport master (
        input  opcode,
        output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, instr_done, illegal
    );

    modport slave (
        output opcode,
        input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, instr_done, illegal
    );

endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. Memory states are held
// for MEM_LAT cycles by an inline wait counter; outputs decode from state,
// counter and the latched branch polarity only.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    mips_multicycle_control_if.master ctl
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             branch_ne_r, branch_ne_next;
    logic             last_wait;

    assign last_wait = (cnt == CNT_LAST);

    // State, wait counter and branch polarity registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            branch_ne_r <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            branch_ne_r <= branch_ne_next;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_next        = state;
        cnt_next          = '0;
        branch_ne_next    = branch_ne_r;
        ctl.pc_write      = 1'b0;
        ctl.pc_write_cond = 1'b0;
        ctl.branch_ne     = 1'b0;
        ctl.iord          = 1'b0;
        ctl.mem_read      = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.mem_to_reg    = 1'b0;
        ctl.reg_dst       = 1'b0;
        ctl.reg_write     = 1'b0;
        ctl.alu_src_a     = 1'b0;
        ctl.alu_src_b     = SRCB_REG;
        ctl.alu_op        = ALU_ADD;
        ctl.pc_src        = PC_SRC_ALU;
        ctl.instr_done    = 1'b0;
        ctl.illegal       = 1'b0;

        // Counter only advances inside a memory state; any exit clears it
        if (is_mem_state(state) && !last_wait) begin
            cnt_next = cnt + CNT_W'(1);
        end

        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                if (last_wait) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_src_b  = SRCB_IMM_SH;
                branch_ne_next = (ctl.opcode == BNE);
                case (ctl.opcode)
                    R_TYPE:   state_next = S_EXEC;
                    ADDI:     state_next = S_ADDIEX;
                    LW, SW:   state_next = S_MEMADR;
                    BEQ, BNE: state_next = S_BRANCH;
                    J:        state_next = S_JUMP;
                    default:  state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                state_next    = (ctl.opcode == SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (last_wait) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (last_wait) begin
                    ctl.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_FUNCT;
                state_next    = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                state_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_src        = PC_SRC_ALUOUT;
                ctl.pc_write_cond = 1'b1;
                ctl.branch_ne     = branch_ne_r;
                ctl.instr_done    = 1'b1;
                state_next        = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PC_SRC_JUMP;
                ctl.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_TRAP: ctl.illegal = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end

endmodule
